// File: rtl/risp_output_collector.sv
// rtl/risp_output_collector.sv - per-output spike count / first-fire collector with record drain
module risp_output_collector #(
    parameter int NUM_OUT     = 1,
    parameter int COUNT_WIDTH = 8,
    parameter int TIME_WIDTH  = 16,
    parameter int IDX_WIDTH   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic                   en,
    input  logic [NUM_OUT-1:0]     fire,
    input  logic                   clear,
    input  logic                   drain,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IDX_WIDTH-1:0]   out_idx,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic [TIME_WIDTH-1:0]  out_first,
    output logic                   out_fired
);

    typedef enum logic {S_COLLECT, S_DRAIN} state_t;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [TIME_WIDTH-1:0]  TIME_MAX  = '1;

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q   [NUM_OUT];
    logic [COUNT_WIDTH-1:0] count_upd [NUM_OUT];
    logic [TIME_WIDTH-1:0]  first_q   [NUM_OUT];
    logic [TIME_WIDTH-1:0]  first_upd [NUM_OUT];
    logic                   fired_q   [NUM_OUT];
    logic                   fired_upd [NUM_OUT];
    logic [TIME_WIDTH-1:0]  time_q, time_upd;
    logic [IDX_WIDTH-1:0]   ptr_q, ptr_nxt;

    logic                   sample, xfer, last_rec;
    logic                   wipe, start, load_next;
    logic [COUNT_WIDTH-1:0] rec_count;
    logic [TIME_WIDTH-1:0]  rec_first;
    logic                   rec_fired;

    assign sample   = (state_q == S_COLLECT) && en && !clear;
    assign xfer     = out_valid && out_ready;
    assign last_rec = (ptr_q == IDX_WIDTH'(NUM_OUT - 1));
    assign ptr_nxt  = ptr_q + 1'b1;
    assign busy     = (state_q == S_DRAIN);

    // State after applying this cycle's fire sample; also feeds record 0 on drain entry.
    always_comb begin
        time_upd = time_q;
        for (int i = 0; i < NUM_OUT; i++) begin
            count_upd[i] = count_q[i];
            first_upd[i] = first_q[i];
            fired_upd[i] = fired_q[i];
            if (sample && fire[i]) begin
                if (count_q[i] != COUNT_MAX) begin
                    count_upd[i] = count_q[i] + 1'b1;
                end
                if (!fired_q[i]) begin
                    first_upd[i] = time_q;
                    fired_upd[i] = 1'b1;
                end
            end
        end
        if (sample && (time_q != TIME_MAX)) begin
            time_upd = time_q + 1'b1;
        end
    end

    // Decoded mux avoids index-width mismatch when NUM_OUT is not a power of two.
    always_comb begin
        rec_count = '0;
        rec_first = '0;
        rec_fired = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (IDX_WIDTH'(i) == ptr_nxt) begin
                rec_count = count_q[i];
                rec_first = first_q[i];
                rec_fired = fired_q[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wipe      = 1'b0;
        start     = 1'b0;
        load_next = 1'b0;
        case (state_q)
            S_COLLECT: begin
                if (clear) begin
                    wipe = 1'b1;
                end else if (drain) begin
                    start   = 1'b1;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (clear) begin
                    wipe    = 1'b1;
                    state_d = S_COLLECT;
                end else if (xfer) begin
                    if (last_rec) begin
                        wipe    = 1'b1;
                        state_d = S_COLLECT;
                    end else begin
                        load_next = 1'b1;
                    end
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q   <= S_COLLECT;
            time_q    <= '0;
            ptr_q     <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_count <= '0;
            out_first <= '0;
            out_fired <= 1'b0;
            for (int i = 0; i < NUM_OUT; i++) begin
                count_q[i] <= '0;
                first_q[i] <= '0;
                fired_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            if (wipe) begin
                time_q    <= '0;
                ptr_q     <= '0;
                out_valid <= 1'b0;
                out_idx   <= '0;
                out_count <= '0;
                out_first <= '0;
                out_fired <= 1'b0;
                for (int i = 0; i < NUM_OUT; i++) begin
                    count_q[i] <= '0;
                    first_q[i] <= '0;
                    fired_q[i] <= 1'b0;
                end
            end else begin
                time_q <= time_upd;
                for (int i = 0; i < NUM_OUT; i++) begin
                    count_q[i] <= count_upd[i];
                    first_q[i] <= first_upd[i];
                    fired_q[i] <= fired_upd[i];
                end
                if (start) begin
                    ptr_q     <= '0;
                    out_valid <= 1'b1;
                    out_idx   <= '0;
                    out_count <= count_upd[0];
                    out_first <= first_upd[0];
                    out_fired <= fired_upd[0];
                end else if (load_next) begin
                    ptr_q     <= ptr_nxt;
                    out_idx   <= ptr_nxt;
                    out_count <= rec_count;
                    out_first <= rec_first;
                    out_fired <= rec_fired;
                end
            end
        end
    end

endmodule
